// File: rtl/demux1_16x1_seq.sv
// ---------------------------------------------------------------------------
// demux1_16x1_seq
//
// Sequential 1-to-16 demultiplexer / deserializer. This is the receive end of
// the 16:1 mux + 4-bit counter serializer. Serial bits land in a registered
// 16-bit word, either in an explicitly addressed lane or in consecutive lanes
// driven by an internal scan counter. A completed auto-scan word is flagged
// with a one-cycle DONE pulse and held until the consumer acknowledges it.
//
// Optional feature, controlled by the macro DEMUX_PARITY_EN:
//   defined   - an auto-scan frame is followed by one even-parity bit. PERR
//               reports the parity check result.
//   undefined - there is no parity phase, and PERR is tied to 0.
//
// Ports:
//   CLK    in   1      rising-edge clock
//   RST    in   1      asynchronous active-low reset
//   D      in   1      serial data bit
//   VALID  in   1      D is valid this cycle
//   READY  out  1      block accepts D this cycle
//   MODE   in   1      0 = addressed, 1 = auto-scan (sampled only in IDLE)
//   S      in   SEL_W  target lane in addressed mode
//   ACK    in   1      consumer has taken Y and releases HOLD
//   CLR    in   1      synchronous clear (wins over VALID and ACK)
//   Y      out  WIDTH  registered lane outputs
//   IDX    out  SEL_W  current scan index
//   DONE   out  1      one-cycle pulse in the first HOLD cycle
//   PERR   out  1      parity error flag
// ---------------------------------------------------------------------------
module demux1_16x1_seq #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             D,
    input  logic             VALID,
    output logic             READY,
    input  logic             MODE,
    input  logic [SEL_W-1:0] S,
    input  logic             ACK,
    input  logic             CLR,
    output logic [WIDTH-1:0] Y,
    output logic [SEL_W-1:0] IDX,
    output logic             DONE,
    output logic             PERR
);

`ifdef DEMUX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2,
        ST_PAR  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;
`endif

    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               mode_q, mode_d;
    logic               done_q, done_d;
`ifdef DEMUX_PARITY_EN
    logic               perr_q, perr_d;
`endif
    logic               xfer;

    // Only HOLD refuses data. Every other state, including PAR, accepts a bit.
    assign READY = (state_q != ST_HOLD);
    assign xfer  = VALID && READY;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
`ifdef DEMUX_PARITY_EN
        perr_d  = perr_q;
`endif
        if (CLR) begin
            state_d = ST_IDLE;
            y_d     = '0;
            idx_d   = '0;
`ifdef DEMUX_PARITY_EN
            perr_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        mode_d = MODE;
                        if (MODE) begin
                            y_d[0]  = D;
                            idx_d   = SEL_W'(1);
                            state_d = ST_FILL;
`ifdef DEMUX_PARITY_EN
                            // A new frame starts with a clean parity flag.
                            perr_d  = 1'b0;
`endif
                        end else begin
                            y_d[S] = D;
                        end
                    end
                end
                ST_FILL: begin
                    // FILL is only reached in auto mode. The mode_q term keeps
                    // the latched mode authoritative for the whole frame.
                    if (xfer && mode_q) begin
                        y_d[idx_q] = D;
                        idx_d      = idx_q + 1'b1;   // wraps to 0 after lane 15
                        if (idx_q == IDX_LAST) begin
`ifdef DEMUX_PARITY_EN
                            state_d = ST_PAR;
`else
                            state_d = ST_HOLD;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
`ifdef DEMUX_PARITY_EN
                ST_PAR: begin
                    // Even parity over the word plus the parity bit must be 0.
                    if (xfer) begin
                        perr_d  = (^y_q) ^ D;
                        done_d  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
`endif
                ST_HOLD: begin
                    // Y is retained on release. The consumer already has it.
                    if (ACK) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DEMUX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
`ifdef DEMUX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign Y    = y_q;
    assign IDX  = idx_q;
    assign DONE = done_q;
`ifdef DEMUX_PARITY_EN
    assign PERR = perr_q;
`else
    assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_demux1_16x1_seq.sv
// ---------------------------------------------------------------------------
// tb_demux1_16x1_seq
//
// Self-checking bench for demux1_16x1_seq. A frame-level reference model
// tracks how many auto-scan bits have been taken in the current frame and
// whether the block is waiting for an acknowledge. A negedge compare process
// checks every DUT output against that model on each cycle. Directed
// scenarios add literal expectations, and a randomized phase follows them.
// Build with +define+DEMUX_PARITY_EN to exercise the parity option.
// ---------------------------------------------------------------------------
module tb_demux1_16x1_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        D = 1'b0;
    logic        VALID = 1'b0;
    logic        MODE = 1'b0;
    logic        ACK = 1'b0;
    logic        CLR = 1'b0;
    logic [3:0]  S = 4'd0;
    logic        READY;
    logic [15:0] Y;
    logic [3:0]  IDX;
    logic        DONE;
    logic        PERR;

    int errors = 0;
    int checks = 0;

    demux1_16x1_seq #(.WIDTH(16), .SEL_W(4)) dut (
        .CLK(CLK), .RST(RST), .D(D), .VALID(VALID), .READY(READY),
        .MODE(MODE), .S(S), .ACK(ACK), .CLR(CLR), .Y(Y), .IDX(IDX),
        .DONE(DONE), .PERR(PERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. m_bits is the number of auto bits taken in the
    // current frame. It is -1 when no auto frame is open, and it is 16
    // while the parity bit is still outstanding.
    // ------------------------------------------------------------------
    logic [15:0] m_y    = 16'h0;
    int          m_bits = -1;
    bit          m_hold = 1'b0;
    bit          m_done = 1'b0;
    bit          m_perr = 1'b0;

    always @(posedge CLK or negedge RST) begin : model
        logic [15:0] ny;
        int          nb;
        bit          nh, nd, np;
        if (!RST) begin
            m_y    <= 16'h0;
            m_bits <= -1;
            m_hold <= 1'b0;
            m_done <= 1'b0;
            m_perr <= 1'b0;
        end else begin
            ny = m_y; nb = m_bits; nh = m_hold; nd = 1'b0; np = m_perr;
            if (CLR) begin
                ny = 16'h0; nb = -1; nh = 1'b0; np = 1'b0;
            end else if (nh) begin
                if (ACK) nh = 1'b0;
            end else if (VALID) begin
                if (nb < 0) begin
                    if (MODE) begin
                        ny[0] = D; nb = 1; np = 1'b0;
                    end else begin
                        ny[S] = D;
                    end
                end else if (nb < 16) begin
                    ny[nb] = D;
                    nb = nb + 1;
`ifndef DEMUX_PARITY_EN
                    if (nb == 16) begin
                        nb = -1; nh = 1'b1; nd = 1'b1;
                    end
`endif
                end else begin
                    np = (^ny) ^ D;
                    nb = -1; nh = 1'b1; nd = 1'b1;
                end
            end
            m_y <= ny; m_bits <= nb; m_hold <= nh; m_done <= nd; m_perr <= np;
        end
    end

    function automatic logic [3:0] m_idx();
        int v;
        v = (m_bits > 0 && m_bits < 16) ? m_bits : 0;
        return v[3:0];
    endfunction

    // Every cycle's outputs are meaningful, so the model is checked on each
    // falling edge.
    always @(negedge CLK) begin
        chk("model_Y", Y, m_y);
        chk("model_IDX", IDX, m_idx());
        chk("model_READY", READY, !m_hold);
        chk("model_DONE", DONE, m_done);
        chk("model_PERR", PERR, m_perr);
    end

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic bit_v);
        VALID = 1'b1; D = bit_v;
        step();
        VALID = 1'b0;
    endtask

    initial begin
        // Reset state, observed before any clock edge.
        #1;
        chk("rst_Y", Y, 16'h0);
        chk("rst_IDX", IDX, 4'h0);
        chk("rst_READY", READY, 1'b1);
        chk("rst_DONE", DONE, 1'b0);
        chk("rst_PERR", PERR, 1'b0);
        #2 RST = 1'b1;
        step();

        // Auto frame 1,0,1,0,... with lane 0 first gives 5555.
        MODE = 1'b1;
        for (int i = 0; i < 16; i++) send((i % 2) == 0);
        chk("auto_Y", Y, 16'h5555);
        chk("auto_IDX", IDX, 4'h0);
`ifdef DEMUX_PARITY_EN
        chk("auto_par_READY", READY, 1'b1);
        chk("auto_par_DONE", DONE, 1'b0);
        send(1'b0);
        chk("par0_PERR", PERR, 1'b0);
`endif
        chk("auto_DONE", DONE, 1'b1);
        chk("auto_READY", READY, 1'b0);
        ACK = 1'b1; step(); ACK = 1'b0;
        chk("ack_READY", READY, 1'b1);
        chk("ack_DONE", DONE, 1'b0);
        chk("ack_Y", Y, 16'h5555);

`ifdef DEMUX_PARITY_EN
        // The same frame with a wrong parity bit.
        for (int i = 0; i < 16; i++) send((i % 2) == 0);
        send(1'b1);
        chk("par1_DONE", DONE, 1'b1);
        chk("par1_PERR", PERR, 1'b1);
        ACK = 1'b1; step(); ACK = 1'b0;
`else
        chk("noparity_PERR", PERR, 1'b0);
`endif

        // Addressed writes to lanes 0, 7 and 15.
        CLR = 1'b1; step(); CLR = 1'b0;
        MODE = 1'b0;
        S = 4'd0;  send(1'b1);
        S = 4'd7;  send(1'b1);
        S = 4'd15; send(1'b1);
        chk("addr_Y", Y, 16'h8081);
        chk("addr_DONE", DONE, 1'b0);
        chk("addr_READY", READY, 1'b1);

        // Gaps in FILL, then a frozen HOLD with ignored data.
        CLR = 1'b1; step(); CLR = 1'b0;
        MODE = 1'b1;
        send(1'b1); send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        step(); step(); step();
        chk("gap_Y", Y, 16'h001B);
        chk("gap_IDX", IDX, 4'd5);
        for (int i = 0; i < 11; i++) send(1'b0);
`ifdef DEMUX_PARITY_EN
        send(1'b0);
`endif
        VALID = 1'b1; D = 1'b0;
        for (int i = 0; i < 4; i++) step();
        VALID = 1'b0;
        chk("hold_Y", Y, 16'h001B);
        chk("hold_READY", READY, 1'b0);
        ACK = 1'b1; step(); ACK = 1'b0;

        // CLR arrives together with the 10th bit of a frame.
        for (int i = 0; i < 9; i++) send(1'b1);
        chk("preclr_IDX", IDX, 4'd9);
        CLR = 1'b1; VALID = 1'b1; D = 1'b1;
        step();
        CLR = 1'b0; VALID = 1'b0;
        chk("clr_Y", Y, 16'h0);
        chk("clr_IDX", IDX, 4'h0);
        chk("clr_READY", READY, 1'b1);

        // Asynchronous reset in the middle of FILL.
        for (int i = 0; i < 5; i++) send(1'b1);
        chk("prerst_IDX", IDX, 4'd5);
        RST = 1'b0;
        #1;
        chk("arst_Y", Y, 16'h0);
        chk("arst_IDX", IDX, 4'h0);
        chk("arst_READY", READY, 1'b1);
        chk("arst_DONE", DONE, 1'b0);
        #1 RST = 1'b1;
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            VALID = ($urandom_range(0, 9) < 7);
            D     = $urandom_range(0, 1);
            MODE  = ($urandom_range(0, 3) != 0);
            S     = 4'($urandom_range(0, 15));
            ACK   = ($urandom_range(0, 9) < 3);
            CLR   = ($urandom_range(0, 99) < 2);
            step();
        end
        VALID = 1'b0; ACK = 1'b0; CLR = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux1_16x1_seq.md
Name: demux1_16x1_seq

Overview:
- Sequential 1-to-16 demultiplexer/deserializer; the receive end of the 16:1 mux + 4-bit counter serializer used in the datapath.
- Routes a 1-bit input stream into a registered 16-bit word, either to an explicit lane (addressed mode) or to consecutive lanes from a scan counter (auto mode).
- Presents a completed word with a DONE pulse and holds it until acknowledged.

Parameters:
- WIDTH, 16, number of output lanes (fixed 16; kept for readability).
- SEL_W, 4, select/scan-index width (log2 WIDTH).

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  reset, asynchronous, active-low.
- D  input  1  serial data bit.
- VALID  input  1  D is valid this cycle.
- READY  output  1  block accepts D this cycle.
- MODE  input  1  0 = addressed, 1 = auto-scan; sampled only in IDLE.
- S  input  SEL_W  target lane in addressed mode; ignored in auto mode.
- ACK  input  1  consumer has taken Y; releases HOLD.
- CLR  input  1  synchronous clear.
- Y  output  WIDTH  registered lane outputs.
- IDX  output  SEL_W  current scan index.
- DONE  output  1  one-cycle pulse when a frame is complete.
- PERR  output  1  parity error flag (see Optional Feature).

Behaviour:
- Reset (RST=0, asynchronous): Y=0, IDX=0, DONE=0, PERR=0, state=IDLE, READY=1 once RST deasserts. Reset mid-frame discards all partial data.
- A transfer occurs on a rising edge when VALID && READY. VALID while READY=0 is ignored; no bit is lost or stored.
- States: IDLE, FILL, HOLD (plus PAR when DEMUX_PARITY_EN is defined).
- IDLE:
  - READY=1.
  - On a transfer, latch MODE into the internal mode register.
  - Addressed mode: Y[S]<=D, stay in IDLE. Addressed mode never pulses DONE and never enters HOLD.
  - Auto mode: Y[0]<=D, IDX<=1, go to FILL.
- FILL (auto mode only):
  - READY=1; each transfer does Y[IDX]<=D, IDX<=IDX+1.
  - The transfer at IDX=15 wraps IDX to 0 and goes to HOLD (or PAR), with DONE=1 in the following cycle.
  - Cycles without VALID leave all state unchanged.
- HOLD:
  - READY=0; Y is frozen.
  - ACK=1 returns to IDLE in the next cycle. Y is retained, not cleared.
  - DONE is high for exactly one cycle: the first HOLD cycle.
  - ACK in the same cycle as DONE is honoured, so HOLD lasts one cycle.
- Latency: the bit written on edge n is visible on Y after edge n. The 16th auto-mode bit and DONE are visible together.
- MODE changes outside IDLE have no effect until the next IDLE transfer.
- CLR=1 (synchronous):
  - Y=0, IDX=0, DONE=0, PERR=0, state=IDLE.
  - Has priority over VALID and ACK in the same cycle.
- Lanes not written keep their previous value; a partial frame does not disturb unwritten lanes.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined:
  - After the 16th auto-mode bit, go to PAR instead of HOLD. PAR has READY=1 and expects one more transfer carrying an even-parity bit.
  - On that transfer, PERR<=(^Y)^D, DONE pulses, and the block enters HOLD.
  - PERR holds until the next IDLE->FILL transition, CLR, or reset.
  - Addressed mode is unaffected.
- Not defined: no PAR state; PERR is tied to 0.

Test Plan:
- Reset: drive RST=0 mid-FILL after 5 bits -> Y=16'h0000, IDX=0, READY=1, DONE=0 immediately, with no clock edge required.
- Auto frame: MODE=1, 16 back-to-back transfers D=1,0,1,0,... (lane 0 first) -> Y=16'h5555 and DONE=1 for one cycle after the 16th edge, READY=0, IDX=0. Then ACK=1 -> IDLE, READY=1, Y still 16'h5555.
- Addressed writes: MODE=0; write D=1 with S=4'b0000, S=4'b0111 and S=4'b1111 -> Y=16'h8081, and DONE is never asserted.
- Backpressure and gaps: in FILL, drop VALID for 3 cycles -> Y and IDX unchanged. In HOLD, VALID=1 with D=0 for 4 cycles and no ACK -> Y unchanged.
- CLR priority: at the 10th bit of a frame, assert CLR=1 together with VALID=1 -> Y=0, IDX=0, state IDLE, and that bit is discarded.
- Parity (DEMUX_PARITY_EN defined):
  - Frame 16'h5555 followed by parity bit 0 -> PERR=0, DONE=1.
  - Same frame with parity bit 1 -> PERR=1.
  - Without the macro, PERR stays 0 throughout.
